load_unit: RTL

//  Read-side counterpart of the MEM-stage store path: issues LW/LH/LB/LHU/LBU reads to data memory over a
//  req/ready + rvalid handshake and stalls the pipeline while the read is outstanding.

---
 rtl/cpu_ld_pkg.sv | 21 ++
 rtl/load_align.sv | 27 ++
 rtl/load_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cpu_ld_pkg.sv
// Shared load/store path types: FSM state encoding, size selectors and datapath widths.
package cpu_ld_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } ld_state_t;

    localparam logic [1:0] SEL_W = 2'd0;
    localparam logic [1:0] SEL_H = 2'd1;
    localparam logic [1:0] SEL_B = 2'd2;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned RD_W     = 5;
    localparam int unsigned OFF_W    = 2;
    localparam int unsigned SEL_BITS = 2;

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a raw memory word and zero/sign-extends it.
module load_align
    import cpu_ld_pkg::*;
(
    input  logic [SEL_BITS-1:0] sel_i,
    input  logic                unsigned_i,
    input  logic [OFF_W-1:0]    off_i,
    input  logic [DATA_W-1:0]   raw_i,
    output logic [DATA_W-1:0]   data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'(raw_i >> {off_i, 3'b000});
        // Halfword offset ignores the low address bit.
        half_v = 16'(raw_i >> {off_i[1], 4'b0000});
        data_o = raw_i;
        case (sel_i)
            SEL_H:   data_o = unsigned_i ? {16'h0000, half_v} : {{16{half_v[15]}}, half_v};
            SEL_B:   data_o = unsigned_i ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// MEM-stage load unit: issues the data-memory read, stalls the pipe while it is in
// flight, and registers the aligned/extended result for the MEM/WB register.
module load_unit
    import cpu_ld_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                MEM_ld_req_in,
    input  logic [SEL_BITS-1:0] MEM_selLWHB,
    input  logic                MEM_ld_unsigned,
    input  logic [OFF_W-1:0]    MEM_ReadAddr_in,
    input  logic [RD_W-1:0]     MEM_rd_in,
    input  logic                MEM_flush_in,
    output logic                DM_req_out,
    input  logic                DM_ready_in,
    input  logic                DM_rvalid_in,
    input  logic [DATA_W-1:0]   DM_RD_in,
    output logic                MEM_ld_stall_out,
    output logic                WB_ld_valid_out,
    output logic [DATA_W-1:0]   WB_ld_data_out,
    output logic [RD_W-1:0]     WB_rd_out,
    output logic                WB_ld_err_out
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    ld_state_t           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SEL_BITS-1:0] sel_q, sel_d;
    logic                uns_q, uns_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [RD_W-1:0]     rd_q, rd_d;
    logic                wb_valid_q, wb_valid_d;
    logic                wb_err_q, wb_err_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [RD_W-1:0]     wb_rd_q, wb_rd_d;

    logic                accept_c;
    logic                timeout_c;
    logic [DATA_W-1:0]   aligned_c;

    load_align u_align (
        .sel_i      (sel_q),
        .unsigned_i (uns_q),
        .off_i      (off_q),
        .raw_i      (DM_RD_in),
        .data_o     (aligned_c)
    );

    assign accept_c  = (state_q == IDLE) && MEM_ld_req_in && !MEM_flush_in;
    assign timeout_c = (cnt_q == CNT_MAX);

    // Request and stall are combinational so a load can issue in its first MEM cycle.
    always_comb begin
        DM_req_out       = accept_c || (state_q == REQ);
        MEM_ld_stall_out = accept_c || (state_q == REQ) || (state_q == WAIT)
                           || (state_q == DRAIN);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        uns_d      = uns_q;
        off_d      = off_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_err_d   = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    sel_d   = MEM_selLWHB;
                    uns_d   = MEM_ld_unsigned;
                    off_d   = MEM_ReadAddr_in;
                    rd_d    = MEM_rd_in;
                    cnt_d   = '0;
                    state_d = DM_ready_in ? WAIT : REQ;
                end
            end
            REQ: begin
                // A flush in the accept cycle still leaves a read outstanding, so drain it.
                if (DM_ready_in) begin
                    cnt_d   = '0;
                    state_d = MEM_flush_in ? DRAIN : WAIT;
                end else if (MEM_flush_in) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = timeout_c ? cnt_q : cnt_q + CNT_W'(1);
                if (DM_rvalid_in) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = aligned_c;
                    wb_rd_d    = rd_q;
                    state_d    = DONE;
                end else if (MEM_flush_in) begin
                    state_d = DRAIN;
                end else if (timeout_c) begin
                    wb_valid_d = 1'b1;
                    wb_err_d   = 1'b1;
                    wb_data_d  = '0;
                    wb_rd_d    = rd_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            DRAIN: begin
                cnt_d = timeout_c ? cnt_q : cnt_q + CNT_W'(1);
                if (DM_rvalid_in || timeout_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_q      <= '0;
            uns_q      <= 1'b0;
            off_q      <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_err_q   <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_err_q   <= wb_err_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

    assign WB_ld_valid_out = wb_valid_q;
    assign WB_ld_err_out   = wb_err_q;
    assign WB_ld_data_out  = wb_data_q;
    assign WB_rd_out       = wb_rd_q;

endmodule
